vx_warp_scheduler: RTL

//  Multi-warp fetch scheduler: holds PC, active bit and thread mask for NUM_WARPS warps.

---
 rtl/vx_warp_scheduler_pkg.sv | 19 +
 rtl/vx_warp_scheduler_if.sv | 61 ++++++
 rtl/vx_warp_scheduler_rr_arbiter.sv | 34 +++
 rtl/vx_warp_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/vx_warp_scheduler_pkg.sv
// rtl/vx_warp_scheduler_pkg.sv - shared constants and types for the warp fetch scheduler
package vx_warp_scheduler_pkg;

    localparam int          DEFAULT_NUM_WARPS   = 4;
    localparam int          DEFAULT_NUM_THREADS = 4;
    localparam int          DEFAULT_PC_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0;

    // Sequential fetch advances one 32-bit instruction per issue
    localparam int          PC_INC              = 4;

    // Which redirect source, if any, rewrites a warp PC this cycle
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_JAL    = 2'd1,
        REDIR_BRANCH = 2'd2
    } redirect_sel_e;

endpackage

// File: rtl/vx_warp_scheduler_if.sv
// rtl/vx_warp_scheduler_if.sv - control/event inputs and fetch outputs of the warp scheduler
interface vx_warp_scheduler_if
    import vx_warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS   = DEFAULT_NUM_WARPS,
    parameter int NUM_THREADS = DEFAULT_NUM_THREADS,
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH
);
    localparam int WW = $clog2(NUM_WARPS);

    logic                   stall;
    logic [NUM_WARPS-1:0]   warp_stall;
    logic                   jal_valid;
    logic [WW-1:0]          jal_warp;
    logic [PC_WIDTH-1:0]    jal_dest;
    logic                   branch_valid;
    logic [WW-1:0]          branch_warp;
    logic [PC_WIDTH-1:0]    branch_dest;
    logic                   mask_valid;
    logic [WW-1:0]          mask_warp;
    logic [NUM_THREADS-1:0] mask_value;
    logic                   wspawn_valid;
    logic [WW:0]            wspawn_count;
    logic [PC_WIDTH-1:0]    wspawn_pc;
    logic                   ebreak_valid;
    logic [WW-1:0]          ebreak_warp;
    logic [31:0]            in_instruction;
    logic                   out_valid;
    logic [WW-1:0]          out_warp_num;
    logic [PC_WIDTH-1:0]    out_curr_PC;
    logic [NUM_THREADS-1:0] out_thread_mask;
    logic [31:0]            out_instruction;
    logic                   out_all_done;

    // Scheduler side
    modport master (
        input  stall, warp_stall,
        input  jal_valid, jal_warp, jal_dest,
        input  branch_valid, branch_warp, branch_dest,
        input  mask_valid, mask_warp, mask_value,
        input  wspawn_valid, wspawn_count, wspawn_pc,
        input  ebreak_valid, ebreak_warp,
        input  in_instruction,
        output out_valid, out_warp_num, out_curr_PC, out_thread_mask,
        output out_instruction, out_all_done
    );

    // Pipeline / environment side
    modport slave (
        output stall, warp_stall,
        output jal_valid, jal_warp, jal_dest,
        output branch_valid, branch_warp, branch_dest,
        output mask_valid, mask_warp, mask_value,
        output wspawn_valid, wspawn_count, wspawn_pc,
        output ebreak_valid, ebreak_warp,
        output in_instruction,
        input  out_valid, out_warp_num, out_curr_PC, out_thread_mask,
        input  out_instruction, out_all_done
    );

endinterface

// File: rtl/vx_warp_scheduler_rr_arbiter.sv
// rtl/vx_warp_scheduler_rr_arbiter.sv - round-robin pick of the first request after the pointer
module vx_rr_arbiter #(
    parameter int N  = 4,
    parameter int WW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [WW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [WW-1:0] grant_idx,
    output logic          grant_valid
);

    int            cand;
    logic [WW-1:0] cand_w;

    // Scan ptr+1, ptr+2, ... wrapping, ending on ptr itself; first hit wins
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_w      = '0;
        for (int i = 1; i <= N; i++) begin
            cand   = (int'(ptr) + i) % N;
            cand_w = WW'(cand);
            if (!grant_valid && req[cand_w]) begin
                grant_valid   = 1'b1;
                grant_idx     = cand_w;
                grant[cand_w] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_warp_scheduler.sv
// rtl/vx_warp_scheduler.sv - multi-warp round-robin fetch scheduler feeding decode
module vx_warp_scheduler
    import vx_warp_scheduler_pkg::*;
#(
    parameter int                  NUM_WARPS   = DEFAULT_NUM_WARPS,
    parameter int                  NUM_THREADS = DEFAULT_NUM_THREADS,
    parameter int                  PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                reset,
    vx_warp_scheduler_if.master sched
);

    localparam int WW = $clog2(NUM_WARPS);

    logic [NUM_WARPS-1:0]   active_vec;
    logic [NUM_WARPS-1:0]   active_next;
    logic [NUM_WARPS-1:0]   eligible;
    logic [NUM_WARPS-1:0]   grant;
    logic [WW-1:0]          grant_idx;
    logic                   grant_valid;
    logic                   issue;
    logic [PC_WIDTH-1:0]    pc_arr   [NUM_WARPS];
    logic [NUM_THREADS-1:0] mask_arr [NUM_WARPS];

    logic [WW-1:0]          ptr_q;
    logic                   out_valid_q;
    logic [WW-1:0]          out_warp_q;
    logic [PC_WIDTH-1:0]    out_pc_q;
    logic [NUM_THREADS-1:0] out_mask_q;
    logic                   out_done_q;

    assign issue = !sched.stall && grant_valid;

    vx_rr_arbiter #(.N(NUM_WARPS), .WW(WW)) u_arb (
        .req         (eligible),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        localparam logic [WW-1:0] WID = WW'(w);

        logic [PC_WIDTH-1:0]    pc_q;
        logic [NUM_THREADS-1:0] mask_q;
        logic                   active_q;
        logic                   jal_hit;
        logic                   br_hit;
        logic                   mask_hit;
        logic                   ebr_hit;
        logic                   spawn_hit;
        logic                   kill;
        redirect_sel_e          redir;

        assign jal_hit   = sched.jal_valid    && (sched.jal_warp    == WID);
        assign br_hit    = sched.branch_valid && (sched.branch_warp == WID);
        assign mask_hit  = sched.mask_valid   && (sched.mask_warp   == WID);
        assign ebr_hit   = sched.ebreak_valid && (sched.ebreak_warp == WID);
        // Warp 0 is never spawned; only inactive warps below the count are woken
        assign spawn_hit = sched.wspawn_valid && (w != 0) && !active_q
                           && ({1'b0, WID} < sched.wspawn_count);
        assign kill      = ebr_hit || (mask_hit && (sched.mask_value == '0));

        // A warp touched by any event this cycle sits out arbitration so the
        // event and a PC+4 never collide on the same register
        assign eligible[w]    = active_q && !sched.warp_stall[w]
                                && !jal_hit && !br_hit && !mask_hit && !ebr_hit;
        assign active_next[w] = spawn_hit || (active_q && !kill);
        assign active_vec[w]  = active_q;
        assign pc_arr[w]      = pc_q;
        assign mask_arr[w]    = mask_q;

        // Redirect source for this warp: jal has priority, inactive warps ignore both
        always_comb begin
            redir = REDIR_NONE;
            if (active_q && jal_hit)
                redir = REDIR_JAL;
            else if (active_q && br_hit)
                redir = REDIR_BRANCH;
        end

        // Per-warp PC, mask and active state
        always_ff @(posedge clk) begin
            if (reset) begin
                active_q <= (w == 0);
                pc_q     <= (w == 0) ? RESET_PC : '0;
                mask_q   <= (w == 0) ? '1 : '0;
            end else begin
                active_q <= active_next[w];
                if (spawn_hit) begin
                    pc_q   <= sched.wspawn_pc;
                    mask_q <= '1;
                end else begin
                    case (redir)
                        REDIR_JAL:    pc_q <= sched.jal_dest;
                        REDIR_BRANCH: pc_q <= sched.branch_dest;
                        default: begin
                            if (issue && grant[w])
                                pc_q <= pc_q + PC_WIDTH'(PC_INC);
                        end
                    endcase
                    if (mask_hit)
                        mask_q <= sched.mask_value;
                end
            end
        end
    end

    // Issue registers and round-robin pointer; outputs hold when nothing issues
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_warp_q  <= '0;
            out_pc_q    <= '0;
            out_mask_q  <= '0;
            out_done_q  <= 1'b0;
        end else begin
            out_done_q <= (active_next == '0);
            if (issue) begin
                ptr_q       <= grant_idx;
                out_valid_q <= 1'b1;
                out_warp_q  <= grant_idx;
                out_pc_q    <= pc_arr[grant_idx];
                out_mask_q  <= mask_arr[grant_idx];
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign sched.out_valid       = out_valid_q;
    assign sched.out_warp_num    = out_warp_q;
    assign sched.out_curr_PC     = out_pc_q;
    assign sched.out_thread_mask = out_mask_q;
    assign sched.out_all_done    = out_done_q;
    // Instruction word is only passed to decode while the pipe is moving
    assign sched.out_instruction = (out_valid_q && !sched.stall) ? sched.in_instruction : 32'b0;

endmodule
